// File: rtl/bcd_seg7_scan.sv
// 4-digit common-anode scanner for the BCD converter's units/tens/hunds digits.
// Build option SEG_LZB_EN: blank leading zeros in the hundreds and tens positions.
module bcd_seg7_scan #(
    parameter int SCAN_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       load,
    input  logic [3:0] units,
    input  logic [3:0] tens,
    input  logic [3:0] hunds,
    output logic [3:0] an_n,
    output logic [6:0] seg_n,
    output logic [1:0] slot
);
    localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

    typedef enum logic [1:0] {S_UNITS, S_TENS, S_HUNDS, S_IDLE} slot_t;

    slot_t         st, st_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [3:0]    u_sh, t_sh, h_sh;
    logic [3:0]    u_nx, t_nx, h_nx;
    logic [3:0]    dig, an_nx;
    logic [6:0]    seg_nx;
    logic          blank, show;

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 7'b1000000;
            4'd1:    decode = 7'b1111001;
            4'd2:    decode = 7'b0100100;
            4'd3:    decode = 7'b0110000;
            4'd4:    decode = 7'b0011001;
            4'd5:    decode = 7'b0010010;
            4'd6:    decode = 7'b0000010;
            4'd7:    decode = 7'b1111000;
            4'd8:    decode = 7'b0000000;
            4'd9:    decode = 7'b0010000;
            default: decode = 7'b0111111;
        endcase
    endfunction

    // Outputs are derived from next-state values so they move on the same edge as cnt/slot.
    always_comb begin
        u_nx   = u_sh;
        t_nx   = t_sh;
        h_nx   = h_sh;
        cnt_nx = cnt;
        st_nx  = st;
        dig    = 4'd0;
        blank  = 1'b0;
        if (load) begin
            u_nx = units;
            t_nx = tens;
            h_nx = hunds;
        end
        if (!en) begin
            cnt_nx = '0;
            st_nx  = S_UNITS;
        end else if (cnt == LAST) begin
            cnt_nx = '0;
            st_nx  = slot_t'(st + 2'd1);
        end else begin
            cnt_nx = cnt + 1'b1;
        end
        case (st_nx)
            S_UNITS: dig = u_nx;
            S_TENS: begin
                dig = t_nx;
`ifdef SEG_LZB_EN
                blank = (h_nx == 4'd0) && (t_nx == 4'd0);
`endif
            end
            S_HUNDS: begin
                dig = h_nx;
`ifdef SEG_LZB_EN
                blank = (h_nx == 4'd0);
`endif
            end
            default: blank = 1'b1;
        endcase
        show   = en && !blank;
        seg_nx = show ? decode(dig) : 7'h7F;
        an_nx  = (show && cnt_nx != '0) ? ~(4'b0001 << st_nx) : 4'hF;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st    <= S_UNITS;
            cnt   <= '0;
            u_sh  <= 4'd0;
            t_sh  <= 4'd0;
            h_sh  <= 4'd0;
            an_n  <= 4'hF;
            seg_n <= 7'h7F;
        end else begin
            st    <= st_nx;
            cnt   <= cnt_nx;
            u_sh  <= u_nx;
            t_sh  <= t_nx;
            h_sh  <= h_nx;
            an_n  <= an_nx;
            seg_n <= seg_nx;
        end
    end

    assign slot = st;
endmodule
